// File: rtl/dot_module_if.sv
// Operand/result bus for dot_module.
//   x[3], y[3]  signed vector operands from a first-word-fall-through FIFO
//   in_empty    input FIFO empty
//   in_rd_en    pop the input FIFO
//   out_full    output FIFO full
//   out         signed dot-product result
//   out_wr_en   push out into the output FIFO
// The slave modport is the dot_module view; master is the FIFO/bench side.
interface dot_module_if #(
  parameter int unsigned DATA_W = 32
);
  logic signed [DATA_W-1:0] x [3];
  logic signed [DATA_W-1:0] y [3];
  logic                     in_empty;
  logic                     in_rd_en;
  logic                     out_full;
  logic signed [DATA_W-1:0] out;
  logic                     out_wr_en;

  modport slave (
    input  x,
    input  y,
    input  in_empty,
    output in_rd_en,
    input  out_full,
    output out,
    output out_wr_en
  );

  modport master (
    output x,
    output y,
    output in_empty,
    input  in_rd_en,
    output out_full,
    input  out,
    input  out_wr_en
  );
endinterface

// File: rtl/dot_module.sv
// Two-stage pipelined signed fixed-point 3-vector dot product,
// out = (x . y) >>> Q_BITS, fed from an FWFT FIFO and writing one scalar
// per operand pair into an output FIFO at up to one result per clock.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   bus        dot_module_if.slave
//                x[3], y[3] (in)  operands, valid while in_empty=0
//                in_empty   (in)  input FIFO empty
//                in_rd_en   (out) input FIFO pop, combinational
//                out_full   (in)  output FIFO full
//                out        (out) registered result
//                out_wr_en  (out) output FIFO push, combinational
//
// Configuration macro DOT_SATURATE_EN:
//   defined   - result clamped to the signed 32-bit range
//   undefined - result is the low 32 bits of the shifted sum (wraps)
module dot_module #(
  parameter int unsigned Q_BITS = 10
) (
  input  logic          clock,
  input  logic          reset,
  dot_module_if.slave   bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = PROD_W + 2;
  localparam int unsigned LANES  = 3;

  // Stage registers
  logic signed [PROD_W-1:0] p_q [LANES];
  logic signed [PROD_W-1:0] p_d [LANES];
  logic                     v1_q, v1_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     v2_q, v2_d;

  // Combinational datapath / handshake
  logic signed [PROD_W-1:0] prod_c [LANES];
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [DATA_W-1:0] res_c;
  logic                     advance_c;
  logic                     rd_c;
  logic                     wr_c;

  // Stage P operands: full-width signed products
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      prod_c[i] = PROD_W'(bus.x[i]) * PROD_W'(bus.y[i]);
    end
  end

  // Stage S: sign-extended sum; two guard bits hold three 64-bit products
  assign sum_c = SUM_W'(p_q[0]) + SUM_W'(p_q[1]) + SUM_W'(p_q[2]);

`ifdef DOT_SATURATE_EN
  logic signed [SUM_W-1:0]  r_c;
  logic [SUM_W-DATA_W:0]    r_hi_c;
  logic                     r_fits_c;

  assign r_c      = sum_c >>> Q_BITS;
  // Fits in 32 bits when every bit from the result sign upward agrees
  assign r_hi_c   = r_c[SUM_W-1:DATA_W-1];
  assign r_fits_c = (&r_hi_c) | ~(|r_hi_c);

  always_comb begin
    res_c = r_c[DATA_W-1:0];
    if (!r_fits_c) begin
      res_c = r_c[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                           : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  // Arithmetic shift floors toward -inf; keep the low word, wrap silently
  assign res_c = DATA_W'(sum_c >>> Q_BITS);
`endif

  // Whole pipe moves together unless a finished result is blocked
  assign advance_c = !v2_q || !bus.out_full;
  assign rd_c      = !bus.in_empty && advance_c && !reset;
  assign wr_c      = v2_q && !bus.out_full && !reset;

  // Next-state for both stages; everything holds on a stall
  always_comb begin
    v1_d  = v1_q;
    v2_d  = v2_q;
    out_d = out_q;
    for (int i = 0; i < int'(LANES); i++) begin
      p_d[i] = p_q[i];
    end
    if (advance_c) begin
      v1_d = rd_c;
      if (rd_c) begin
        for (int i = 0; i < int'(LANES); i++) begin
          p_d[i] = prod_c[i];
        end
      end
      v2_d = v1_q;
      if (v1_q) begin
        out_d = res_c;
      end
    end
  end

  // State registers; reset drops any in-flight pairs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      out_q <= '0;
      for (int i = 0; i < int'(LANES); i++) begin
        p_q[i] <= '0;
      end
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      out_q <= out_d;
      for (int i = 0; i < int'(LANES); i++) begin
        p_q[i] <= p_d[i];
      end
    end
  end

  assign bus.in_rd_en  = rd_c;
  assign bus.out_wr_en = wr_c;
  assign bus.out       = out_q;

endmodule

// File: tb/tb_dot_module.sv
// Self-checking bench for dot_module: directed single-pair vectors from a
// table, then streaming, output stall and mid-flight reset sequences.
module tb_dot_module;

  logic clock;
  logic reset;

  dot_module_if #(.DATA_W(32)) bus ();

  dot_module #(.Q_BITS(10)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] x0, x1, x2;
    logic [31:0] y0, y1, y2;
    logic [31:0] exp;
  } vec_t;

  localparam logic [31:0] P21 = 32'h0020_0000;  // 2^21
  localparam logic [31:0] N21 = 32'hFFE0_0000;  // -2^21
  localparam logic [31:0] P20 = 32'h0010_0000;  // 2^20
  localparam logic [31:0] MIN = 32'h8000_0000;  // -2^31

`ifdef DOT_SATURATE_EN
  localparam logic [31:0] E_POS_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] E_NEG_OVF = 32'h8000_0000;
  localparam logic [31:0] E_2P31    = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] E_POS_OVF = 32'h0000_0000;
  localparam logic [31:0] E_NEG_OVF = 32'h0000_0000;
  localparam logic [31:0] E_2P31    = 32'h8000_0000;
`endif

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  logic [31:0] sx   [8][3];
  logic [31:0] sy   [8][3];
  logic [31:0] sexp [8];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] a0, a1, a2, b0, b1, b2);
    bus.x[0] = a0; bus.x[1] = a1; bus.x[2] = a2;
    bus.y[0] = b0; bus.y[1] = b1; bus.y[2] = b2;
  endtask

  // One pair into an empty pipe: pop, result two clocks later for one cycle
  task automatic apply_vec(input int i);
    @(negedge clock);
    drive(vecs[i].x0, vecs[i].x1, vecs[i].x2, vecs[i].y0, vecs[i].y1, vecs[i].y2);
    bus.in_empty = 1'b0;
    bus.out_full = 1'b0;
    #1 check($sformatf("vec%0d_rd_en", i), 32'(bus.in_rd_en), 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.in_empty = 1'b1;
    #1 check($sformatf("vec%0d_wr_early", i), 32'(bus.out_wr_en), 32'd0);
    @(posedge clock);
    @(negedge clock);
    #1 check($sformatf("vec%0d_wr_en", i), 32'(bus.out_wr_en), 32'd1);
    check($sformatf("vec%0d_out", i), bus.out, vecs[i].exp);
    @(posedge clock);
    @(negedge clock);
    #1 check($sformatf("vec%0d_wr_pulse", i), 32'(bus.out_wr_en), 32'd0);
  endtask

  // Stream n pairs from the stream table, optionally stalling the output
  task automatic run_stream(input int n, input int st0, input int stl, input bit timing);
    int rd  = 0;
    int wr  = 0;
    int cyc = 0;
    while (wr < n && cyc < 200) begin
      @(negedge clock);
      bus.in_empty = (rd >= n);
      if (rd < n) drive(sx[rd][0], sx[rd][1], sx[rd][2], sy[rd][0], sy[rd][1], sy[rd][2]);
      bus.out_full = (cyc >= st0) && (cyc < st0 + stl);
      #1;
      if (bus.out_full) begin
        check($sformatf("stall_rd_c%0d", cyc), 32'(bus.in_rd_en), 32'd0);
        check($sformatf("stall_wr_c%0d", cyc), 32'(bus.out_wr_en), 32'd0);
        check($sformatf("stall_hold_c%0d", cyc), bus.out, sexp[wr]);
      end
      if (bus.out_wr_en) begin
        check($sformatf("stream_out%0d", wr), bus.out, sexp[wr]);
        if (timing) check($sformatf("stream_wr_cyc%0d", wr), 32'(cyc), 32'(wr + 2));
        wr++;
      end
      if (bus.in_rd_en) begin
        if (timing) check($sformatf("stream_rd_cyc%0d", rd), 32'(cyc), 32'(rd));
        rd++;
      end
      cyc++;
    end
    check("stream_writes", 32'(wr), 32'(n));
    check("stream_pops", 32'(rd), 32'(n));
    @(negedge clock);
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("stream_no_extra%0d", k), 32'(bus.out_wr_en), 32'd0);
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd1024, 32'd2048, 32'd3072, 32'd4096, 32'd5120, 32'd6144, 32'd32768};
    vecs[1] = '{32'hFFFF_FC00, 32'd0, 32'd0, 32'd1024, 32'd0, 32'd0, 32'hFFFF_FC00};
    vecs[2] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF};
    vecs[3] = '{P21, 32'd0, 32'd0, P21, 32'd0, 32'd0, E_POS_OVF};
    vecs[4] = '{N21, 32'd0, 32'd0, P21, 32'd0, 32'd0, E_NEG_OVF};
    vecs[5] = '{MIN, MIN, MIN, MIN, MIN, MIN, E_POS_OVF};
    vecs[6] = '{32'd3000, 32'hFFFF_F830, 32'd500, 32'd700, 32'd400, 32'hFFFF_FB50, 32'd683};
    vecs[7] = '{32'd1536, 32'd0, 32'd0, 32'hFFFF_F600, 32'd0, 32'd0, 32'hFFFF_F100};
    vecs[8] = '{P21, 32'hFFFF_FC00, 32'd0, P20, 32'd1, 32'd0, 32'h7FFF_FFFF};
    vecs[9] = '{P21, 32'd0, 32'd0, P20, 32'd0, 32'd0, E_2P31};

    // Pair k: x=(1024(k+1),2048,0), y=(1024,-1024k,0) -> 1024(1-k)
    for (int k = 0; k < 8; k++) begin
      sx[k][0] = 32'(1024 * (k + 1)); sx[k][1] = 32'd2048;        sx[k][2] = 32'd0;
      sy[k][0] = 32'd1024;            sy[k][1] = 32'(-1024 * k);  sy[k][2] = 32'd0;
    end
    sexp[0] = 32'd1024;      sexp[1] = 32'd0;
    sexp[2] = 32'hFFFF_FC00; sexp[3] = 32'hFFFF_F800;
    sexp[4] = 32'hFFFF_F400; sexp[5] = 32'hFFFF_F000;
    sexp[6] = 32'hFFFF_EC00; sexp[7] = 32'hFFFF_E800;

    // Reset state, with data waiting to confirm pops are suppressed
    reset = 1'b1;
    bus.in_empty = 1'b0;
    bus.out_full = 1'b0;
    drive(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6);
    @(negedge clock);
    @(negedge clock);
    #1;
    check("rst_out", bus.out, 32'd0);
    check("rst_wr_en", 32'(bus.out_wr_en), 32'd0);
    check("rst_rd_en", 32'(bus.in_rd_en), 32'd0);
    bus.in_empty = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) apply_vec(i);

    run_stream(8, 1000, 0, 1'b1);
    run_stream(8, 4, 5, 1'b0);

    // Reset with two pairs in flight
    @(negedge clock);
    drive(vecs[0].x0, vecs[0].x1, vecs[0].x2, vecs[0].y0, vecs[0].y1, vecs[0].y2);
    bus.in_empty = 1'b0;
    bus.out_full = 1'b0;
    @(posedge clock);
    @(negedge clock);
    drive(vecs[1].x0, vecs[1].x1, vecs[1].x2, vecs[1].y0, vecs[1].y1, vecs[1].y2);
    @(posedge clock);
    #2;
    check("pre_rst_wr_en", 32'(bus.out_wr_en), 32'd1);
    check("pre_rst_out", bus.out, vecs[0].exp);
    reset = 1'b1;
    #1;
    check("mid_rst_out", bus.out, 32'd0);
    check("mid_rst_wr_en", 32'(bus.out_wr_en), 32'd0);
    check("mid_rst_rd_en", 32'(bus.in_rd_en), 32'd0);
    @(negedge clock);
    bus.in_empty = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1 check($sformatf("post_rst_quiet%0d", k), 32'(bus.out_wr_en), 32'd0);
    end
    run_stream(1, 1000, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
